// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank: independent AW/W holding slots, one outstanding write
// and one outstanding read, every output registered.
module axi4_lite_slave_regs #(
  parameter int C_ADDR_BITS  = 16,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_REG_COUNT  = 16,
  localparam int IDX_W  = $clog2(C_REG_COUNT),
  localparam int STRB_W = C_DATA_WIDTH / 8
) (
  input  logic                              MCLK,
  input  logic                              nRST,
  input  logic [C_ADDR_BITS-1:0]            S_AWADDR,
  input  logic                              S_AWVALID,
  output logic                              S_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]           S_WDATA,
  input  logic [STRB_W-1:0]                 S_WSTRB,
  input  logic                              S_WVALID,
  output logic                              S_WREADY,
  output logic [1:0]                        S_BRESP,
  output logic                              S_BVALID,
  input  logic                              S_BREADY,
  input  logic [C_ADDR_BITS-1:0]            S_ARADDR,
  input  logic                              S_ARVALID,
  output logic                              S_ARREADY,
  output logic [C_DATA_WIDTH-1:0]           S_RDATA,
  output logic [1:0]                        S_RRESP,
  output logic                              S_RVALID,
  input  logic                              S_RREADY,
  output logic [C_DATA_WIDTH*C_REG_COUNT-1:0] REGS,
  output logic                              REG_WE,
  output logic [IDX_W-1:0]                  REG_INDEX
);

  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * C_REG_COUNT);

  logic                                      aw_full, w_full;
  logic [C_ADDR_BITS-1:0]                    aw_addr;
  logic [C_DATA_WIDTH-1:0]                   w_data;
  logic [STRB_W-1:0]                         w_strb;
  logic [C_REG_COUNT-1:0][C_DATA_WIDTH-1:0]  regs;

  logic aw_hs, w_hs, ar_hs, commit;
  logic aw_full_n, w_full_n, bvalid_n, rvalid_n;
  logic wr_ok, rd_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Handshake rule: a beat transfers on a rising MCLK edge where VALID and READY
  // are both high; a source holds VALID and payload steady until that edge.
  // READY flags are computed from next-state slot/response values so they are
  // registered and never depend combinationally on any VALID.
  assign aw_hs  = S_AWVALID & S_AWREADY;
  assign w_hs   = S_WVALID & S_WREADY;
  assign ar_hs  = S_ARVALID & S_ARREADY;
  assign commit = aw_full & w_full;

  assign aw_full_n = !commit && (aw_full || aw_hs);
  assign w_full_n  = !commit && (w_full || w_hs);
  assign bvalid_n  = commit || (S_BVALID && !S_BREADY);
  assign rvalid_n  = ar_hs || (S_RVALID && !S_RREADY);

  assign wr_ok  = 32'(aw_addr) < ADDR_LIMIT;
  assign rd_ok  = 32'(S_ARADDR) < ADDR_LIMIT;
  assign wr_idx = aw_addr[IDX_W+1:2];
  assign rd_idx = S_ARADDR[IDX_W+1:2];

  assign REGS = regs;

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      regs      <= '0;
      S_AWREADY <= 1'b0;
      S_WREADY  <= 1'b0;
      S_BVALID  <= 1'b0;
      S_BRESP   <= RESP_OKAY;
      S_ARREADY <= 1'b0;
      S_RVALID  <= 1'b0;
      S_RDATA   <= '0;
      S_RRESP   <= RESP_OKAY;
      REG_WE    <= 1'b0;
      REG_INDEX <= '0;
    end else begin
      aw_full   <= aw_full_n;
      w_full    <= w_full_n;
      S_AWREADY <= !aw_full_n && !bvalid_n;
      S_WREADY  <= !w_full_n && !bvalid_n;
      S_BVALID  <= bvalid_n;
      REG_WE    <= 1'b0;

      if (aw_hs) aw_addr <= S_AWADDR;
      if (w_hs) begin
        w_data <= S_WDATA;
        w_strb <= S_WSTRB;
      end

      if (commit) begin
        S_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (w_strb[k]) regs[wr_idx][8*k +: 8] <= w_data[8*k +: 8];
          end
          REG_WE    <= 1'b1;
          REG_INDEX <= wr_idx;
        end
      end

      // The read samples regs before this edge's commit lands, so a same-edge
      // read of the written register returns the old contents.
      S_ARREADY <= !rvalid_n;
      S_RVALID  <= rvalid_n;
      if (ar_hs) begin
        S_RDATA <= rd_ok ? regs[rd_idx] : '0;
        S_RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite responder (slave end) for the MCLK-domain control bus driven by the system's AXI4-Lite master. It holds a bank of 32-bit control/status registers and answers writes and reads with OKAY or SLVERR. It exposes the register contents and a per-write notification pulse to the processor core inside dut_top. It is the register front-end a new DUT instantiates behind its S_* port group.

Parameters:
C_ADDR_BITS, 16, width of S_AWADDR/S_ARADDR (byte address)
C_DATA_WIDTH, 32, data width; fixed at 32 (other values unsupported)
C_REG_COUNT, 16, number of registers (power of two, 2..256)

Ports:
MCLK  input  1  system clock
nRST  input  1  asynchronous active-low reset
S_AWADDR  input  C_ADDR_BITS  write address
S_AWVALID  input  1  write address valid
S_AWREADY  output  1  write address ready
S_WDATA  input  32  write data
S_WSTRB  input  4  byte strobes
S_WVALID  input  1  write data valid
S_WREADY  output  1  write data ready
S_BRESP  output  2  write response
S_BVALID  output  1  write response valid
S_BREADY  input  1  write response ready
S_ARADDR  input  C_ADDR_BITS  read address
S_ARVALID  input  1  read address valid
S_ARREADY  output  1  read address ready
S_RDATA  output  32  read data
S_RRESP  output  2  read response
S_RVALID  output  1  read data valid
S_RREADY  input  1  read data ready
REGS  output  32*C_REG_COUNT  flattened register contents; reg i at [32*i+31:32*i]
REG_WE  output  1  one-cycle pulse on each committed write
REG_INDEX  output  log2(C_REG_COUNT)  index of the committed write (valid with REG_WE)

Behaviour:
- Reset (nRST low, async): all registers 0. AWREADY, WREADY, ARREADY, BVALID, RVALID, REG_WE = 0. BRESP, RRESP, RDATA, REG_INDEX = 0. Reset mid-transaction discards the pending state; no response is issued afterwards.
- Write path: independent AW and W holding slots.
  - S_AWREADY = AW slot empty and BVALID low. S_WREADY = W slot empty and BVALID low.
  - AW and W are accepted in any order or in the same cycle. Each slot captures on its VALID&READY.
- Commit: on the first edge where both slots are full, perform the write and clear both slots. BVALID rises on that same edge.
  - Latency: AW+W handshaked at edge N gives BVALID high after edge N+1.
- Decode: index = addr[log2(C_REG_COUNT)+1:2]; addr[1:0] ignored.
  - addr >= 4*C_REG_COUNT: no register change, BRESP = 2'b10 (SLVERR), REG_WE stays 0.
  - Otherwise byte k is updated only where WSTRB[k]=1, BRESP = 2'b00, REG_WE = 1 for exactly one cycle, REG_INDEX = index.
  - WSTRB = 0 in range: no change, OKAY, REG_WE still pulses.
- BVALID/BRESP hold until BREADY is sampled high, then drop next cycle. New AW/W are blocked while BVALID is high. One outstanding write.
- Read path:
  - S_ARREADY = !RVALID.
  - On AR handshake at edge N, RDATA/RRESP are registered and RVALID is high after N. Read-to-RVALID is 1 cycle.
  - Out of range: RDATA = 0, RRESP = 2'b10.
  - RDATA/RRESP/RVALID hold until RREADY. ARREADY returns high the cycle after the R handshake. One outstanding read.
- Simultaneous read and commit to the same register on one edge: read returns the pre-write value.
- Read and write channels operate concurrently with no mutual stalls.
- Protocol: no combinational path from any VALID to any READY. All outputs are registered.

Test Plan:
1. Reset, then AW=0x0008 and W=0xDEADBEEF/strb 0xF in the same cycle -> BVALID=1/BRESP=00 one cycle later; REGS[95:64]=0xDEADBEEF; REG_WE pulse with REG_INDEX=2. Read 0x0008 -> RDATA=0xDEADBEEF, RRESP=00.
2. W first (0x11223344, strb 0x5), AW 3 cycles later to 0x0004 (reg1 previously 0xFFFFFFFF) -> reg1=0xFF22FF44; BVALID only after AW accepted.
3. Write 0x0040 with C_REG_COUNT=16 -> BRESP=10, REGS unchanged, no REG_WE. Read 0x0040 -> RDATA=0, RRESP=10.
4. Hold BREADY low 5 cycles after a write -> BVALID/BRESP stable, AWREADY/WREADY low throughout. A second AW offered in that window is accepted only after the B handshake.
5. Same-edge read of reg3 and commit of 0xCAFEF00D to reg3 (old value 0x12345678) -> RDATA=0x12345678; next read returns 0xCAFEF00D.
6. Assert nRST low while AW is captured but W is pending; release, then send W alone -> no write occurs, no BVALID; WREADY is high and the W beat sits in its slot awaiting AW.
